counter_match_arbiter: RTL and testbench

//  Sequences and shares the multi-mode counter game between NUM_PLAYERS requesters.

---
 rtl/counter_match_arbiter.sv | 143 ++++++++++++++
 tb/tb_counter_match_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/counter_match_arbiter.sv
// Round-robin arbiter that time-shares the counter game between players
// and keeps a best-of match score from the counter's GAMEOVER/WHO.
module counter_match_arbiter #(
  parameter int NUM_PLAYERS   = 2,
  parameter int HOLD_CYCLES   = 4,
  parameter int ROUNDS_TO_WIN = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NUM_PLAYERS-1:0]     req,
  input  logic [2*NUM_PLAYERS-1:0]   req_mode,
  input  logic [NUM_PLAYERS-1:0]     req_init,
  input  logic [4*NUM_PLAYERS-1:0]   req_load,
  input  logic                       gameover,
  input  logic [1:0]                 who,
  output logic [NUM_PLAYERS-1:0]     gnt,
  output logic [1:0]                 mode_control,
  output logic                       init,
  output logic [3:0]                 load_value,
  output logic                       busy,
  output logic                       round_done,
  output logic [3:0]                 win_tally,
  output logic [3:0]                 loss_tally,
  output logic                       match_done,
  output logic [1:0]                 match_result
);
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic [3:0] R = 4'(ROUNDS_TO_WIN);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_HOLD, S_ROUND_END, S_MATCH_DONE} state_t;
  state_t state, state_nxt;

  logic [PW-1:0] rr_ptr, pick, cand;
  logic          pick_vld, grant, go_rise, gameover_q;
  logic [7:0]    hold_cnt;
  logic [3:0]    win_nxt, loss_nxt;
  logic [1:0]    mode_arr [NUM_PLAYERS];
  logic [3:0]    load_arr [NUM_PLAYERS];

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_lane
    assign mode_arr[g] = req_mode[2*g +: 2];
    assign load_arr[g] = req_load[4*g +: 4];
  end

  assign go_rise = gameover & ~gameover_q;

  // Scan downward from farthest to nearest so the nearest requester after rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    cand     = '0;
    for (int i = NUM_PLAYERS; i >= 1; i--) begin
      cand = PW'((int'(rr_ptr) + i) % NUM_PLAYERS);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    gnt       = '0;
    win_nxt   = win_tally;
    loss_nxt  = loss_tally;
    unique case (state)
      S_IDLE: if (start) state_nxt = S_ARB;
      S_ARB: begin
        if (go_rise) state_nxt = S_ROUND_END;
        else if (pick_vld) begin
          grant     = 1'b1;
          gnt[pick] = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (go_rise) state_nxt = S_ROUND_END;
        else if (hold_cnt == 8'd0) state_nxt = S_ARB;
      end
      S_ROUND_END: begin
        if (who == 2'b10 && win_tally != R) win_nxt = win_tally + 4'd1;
        else if (who == 2'b01 && loss_tally != R) loss_nxt = loss_tally + 4'd1;
        state_nxt = (win_nxt == R || loss_nxt == R) ? S_MATCH_DONE : S_ARB;
      end
      S_MATCH_DONE: if (start) state_nxt = S_ARB;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy       = (state == S_ARB) || (state == S_HOLD) || (state == S_ROUND_END);
  assign round_done = (state == S_ROUND_END);
  assign match_done = (state == S_MATCH_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= PW'(NUM_PLAYERS-1);
      hold_cnt     <= '0;
      gameover_q   <= 1'b0;
      mode_control <= '0;
      load_value   <= '0;
      init         <= 1'b0;
      win_tally    <= '0;
      loss_tally   <= '0;
      match_result <= '0;
    end else begin
      state      <= state_nxt;
      gameover_q <= gameover;
      init       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          mode_control <= '0;
          if (start) begin
            win_tally    <= '0;
            loss_tally   <= '0;
            match_result <= '0;
          end
        end
        S_ARB: if (grant) begin
          mode_control <= mode_arr[pick];
          load_value   <= load_arr[pick];
          init         <= req_init[pick];
          rr_ptr       <= pick;
          hold_cnt     <= 8'(HOLD_CYCLES-1);
        end
        S_HOLD: if (!go_rise && hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
        S_ROUND_END: begin
          win_tally  <= win_nxt;
          loss_tally <= loss_nxt;
          if (state_nxt == S_MATCH_DONE) match_result <= (win_nxt == R) ? 2'b10 : 2'b01;
        end
        S_MATCH_DONE: if (start) begin
          win_tally    <= '0;
          loss_tally   <= '0;
          match_result <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_counter_match_arbiter.sv
// Directed then random stimulus against a phase/countdown model of the match arbiter.
module tb_counter_match_arbiter;
  localparam int N = 2;
  localparam int H = 4;
  localparam int R = 3;

  logic clk = 1'b0, rst_n;
  logic start, gameover;
  logic [N-1:0] req, req_init, gnt;
  logic [2*N-1:0] req_mode;
  logic [4*N-1:0] req_load;
  logic [1:0] who, mode_control, match_result;
  logic [3:0] load_value, win_tally, loss_tally;
  logic init, busy, round_done, match_done;

  int tests = 0, fails = 0;

  counter_match_arbiter #(.NUM_PLAYERS(N), .HOLD_CYCLES(H), .ROUNDS_TO_WIN(R)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req(req), .req_mode(req_mode),
    .req_init(req_init), .req_load(req_load), .gameover(gameover), .who(who),
    .gnt(gnt), .mode_control(mode_control), .init(init), .load_value(load_value),
    .busy(busy), .round_done(round_done), .win_tally(win_tally), .loss_tally(loss_tally),
    .match_done(match_done), .match_result(match_result));

  always #5 clk = ~clk;

  // Model: a phase name, a countdown of hold cycles left, the last player served,
  // integer scores, and the settings currently driven to the counter.
  string m_phase;
  int    m_left, m_last, m_win, m_loss;
  logic  [1:0] m_mode, m_res;
  logic  [3:0] m_load;
  logic  m_init, m_go_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = "idle"; m_left = 0; m_last = N-1; m_win = 0; m_loss = 0;
    m_mode = 0; m_res = 0; m_load = 0; m_init = 0; m_go_prev = 0;
  endtask

  function automatic int next_player(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (((r >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
    return -1;
  endfunction

  // One clock: inputs are already applied; compare, clock, advance model.
  task automatic cyc();
    bit rise;
    int p;
    logic [N-1:0] eg;
    #1;
    if (!rst_n) m_reset();
    rise = gameover && !m_go_prev;
    p = (m_phase == "arb" && !rise) ? next_player(req, m_last) : -1;
    eg = (p >= 0) ? (N'(1) << p) : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(m_phase == "arb" || m_phase == "hold" || m_phase == "round"));
    chk("round_done", 32'(round_done), 32'(m_phase == "round"));
    chk("match_done", 32'(match_done), 32'(m_phase == "done"));
    chk("match_result", 32'(match_result), 32'(m_res));
    chk("mode_control", 32'(mode_control), 32'(m_mode));
    chk("load_value", 32'(load_value), 32'(m_load));
    chk("init", 32'(init), 32'(m_init));
    chk("win_tally", 32'(win_tally), 32'(m_win));
    chk("loss_tally", 32'(loss_tally), 32'(m_loss));
    @(posedge clk);
    if (rst_n) begin
      m_go_prev = gameover;
      m_init = 0;
      if (m_phase == "idle") begin
        if (start) begin m_win = 0; m_loss = 0; m_res = 0; m_phase = "arb"; end
      end else if (m_phase == "arb") begin
        if (rise) m_phase = "round";
        else if (p >= 0) begin
          m_mode = 2'(req_mode >> (2*p));
          m_load = 4'(req_load >> (4*p));
          m_init = req_init[p];
          m_last = p; m_left = H; m_phase = "hold";
        end
      end else if (m_phase == "hold") begin
        if (rise) m_phase = "round";
        else begin
          m_left--;
          if (m_left == 0) m_phase = "arb";
        end
      end else if (m_phase == "round") begin
        if (who == 2'b10) m_win = (m_win + 1 > R) ? R : m_win + 1;
        else if (who == 2'b01) m_loss = (m_loss + 1 > R) ? R : m_loss + 1;
        if (m_win == R || m_loss == R) begin
          m_res = (m_win == R) ? 2'b10 : 2'b01;
          m_phase = "done";
        end else m_phase = "arb";
      end else if (m_phase == "done") begin
        if (start) begin m_win = 0; m_loss = 0; m_res = 0; m_phase = "arb"; end
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst_n = 0; start = 0; req = 0; req_mode = 0; req_init = 0; req_load = 0;
    gameover = 0; who = 0;
    m_reset();
    @(negedge clk);
    run(2);
    rst_n = 1;
    run(1);
    // 1: single requester, mode 01, held then back to arbitration
    start = 1; run(1); start = 0;
    req = 2'b01; req_mode = 4'b0001; run(1);
    req = 0; run(7);
    // 2: both request continuously, grants alternate
    req = 2'b11; req_mode = 4'b1001; req_load = 8'h53; run(20);
    req = 0; run(6);
    // 3: load strobe with value E
    req = 2'b01; req_init = 2'b01; req_load = 8'h0E; run(1);
    req = 0; req_init = 0; run(6);
    // 4: three won rounds finish the match
    who = 2'b10;
    for (int k = 0; k < 3; k++) begin
      gameover = 1; run(1); gameover = 0; run(3);
    end
    chk("t4_match_done", 32'(match_done), 32'd1);
    chk("t4_match_result", 32'(match_result), 32'h2);
    chk("t4_win_tally", 32'(win_tally), 32'd3);
    // 5: go_rise collides with a pending request in ARB
    start = 1; run(1); start = 0;
    req = 2'b10; gameover = 1; who = 2'b01; run(1);
    gameover = 0; run(8);
    req = 0; run(6);
    // 6: reset mid-hold while init is high, then player 0 wins first
    req = 2'b01; req_init = 2'b01; req_load = 8'hA7; run(1);
    req = 0; req_init = 0;
    rst_n = 0; run(1);
    rst_n = 1; run(1);
    start = 1; run(1); start = 0;
    req = 2'b11; run(1);
    req = 0; run(5);
    // held gameover scores once
    gameover = 1; who = 2'b01; run(6); gameover = 0; run(3);
    // random phase
    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      start    = ($urandom_range(0, 7) == 0);
      req      = N'($urandom);
      req_mode = (2*N)'($urandom);
      req_init = N'($urandom);
      req_load = (4*N)'($urandom);
      gameover = ($urandom_range(0, 3) == 0);
      who      = 2'($urandom);
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
